// File: rtl/dmem_copy_engine_pkg.sv
// rtl/dmem_copy_engine_pkg.sv - shared data-memory definitions and copy-engine types
package MiniLab_defs;

  localparam int DMEM_DEPTH = 6;
  localparam int DMA_LEN_W  = DMEM_DEPTH + 1;

  typedef enum logic {DMA_COPY, DMA_FILL} dma_mode_t;

endpackage

// File: rtl/dmem_copy_engine.sv
// rtl/dmem_copy_engine.sv - block copy / fill initiator on a data-memory arbiter port
module dmem_copy_engine
  import MiniLab_defs::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  dma_mode_t             mode_i,
  input  logic [DMEM_DEPTH-1:0] src_i,
  input  logic [DMEM_DEPTH-1:0] dst_i,
  input  logic [DMA_LEN_W-1:0]  len_i,
  input  logic [15:0]           pattern_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  req_o,
  input  logic                  gnt_i,
  output logic                  we_o,
  output logic [DMEM_DEPTH-1:0] addr_o,
  output logic [15:0]           wdata_o,
  input  logic [15:0]           rdata_i
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t                state, next_state;
  dma_mode_t             mode_r;
  logic [DMEM_DEPTH-1:0] src_r, dst_r;
  logic [DMA_LEN_W-1:0]  cnt_r;
  logic [15:0]           pattern_r, data_r;
  logic                  busy_r;

  assign busy_o = busy_r;

  // addr_o depends only on registered state so dmem sees it stable from the posedge.
  always_comb begin
    next_state = state;
    req_o      = 1'b0;
    we_o       = 1'b0;
    addr_o     = '0;
    wdata_o    = '0;
    done_o     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_i) begin
          if (len_i == '0)            next_state = S_DONE;
          else if (mode_i == DMA_COPY) next_state = S_READ;
          else                         next_state = S_WRITE;
        end
      end
      S_READ: begin
        req_o  = 1'b1;
        addr_o = src_r;
        if (gnt_i) next_state = S_WRITE;
      end
      S_WRITE: begin
        req_o   = 1'b1;
        we_o    = 1'b1;
        addr_o  = dst_r;
        wdata_o = (mode_r == DMA_FILL) ? pattern_r : data_r;
        if (gnt_i) begin
          if (cnt_r == DMA_LEN_W'(1))  next_state = S_DONE;
          else if (mode_r == DMA_COPY) next_state = S_READ;
          else                         next_state = S_WRITE;
        end
      end
      S_DONE: begin
        done_o     = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      mode_r    <= DMA_COPY;
      src_r     <= '0;
      dst_r     <= '0;
      cnt_r     <= '0;
      pattern_r <= '0;
      data_r    <= '0;
      busy_r    <= 1'b0;
    end else begin
      state  <= next_state;
      busy_r <= (next_state == S_READ) || (next_state == S_WRITE);
      case (state)
        S_IDLE: begin
          if (start_i) begin
            mode_r    <= mode_i;
            src_r     <= src_i;
            dst_r     <= dst_i;
            cnt_r     <= len_i;
            pattern_r <= pattern_i;
          end
        end
        S_READ: begin
          if (gnt_i) begin
            data_r <= rdata_i;
            src_r  <= src_r + DMEM_DEPTH'(1);
          end
        end
        S_WRITE: begin
          if (gnt_i) begin
            dst_r <= dst_r + DMEM_DEPTH'(1);
            cnt_r <= cnt_r - DMA_LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_copy_engine.sv
// tb/tb_dmem_copy_engine.sv - self-checking bench for dmem_copy_engine
module tb_dmem_copy_engine;
  import MiniLab_defs::*;

  localparam int WORDS = 1 << DMEM_DEPTH;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start_i;
  dma_mode_t             mode_i;
  logic [DMEM_DEPTH-1:0] src_i, dst_i;
  logic [DMA_LEN_W-1:0]  len_i;
  logic [15:0]           pattern_i;
  logic                  busy_o, done_o, req_o, gnt_i, we_o;
  logic [DMEM_DEPTH-1:0] addr_o;
  logic [15:0]           wdata_o, rdata_i;

  logic [15:0] mem     [WORDS];
  logic [15:0] ref_mem [WORDS];

  int checks = 0;
  int errors = 0;

  dmem_copy_engine dut (
    .clk(clk), .rst(rst), .start_i(start_i), .mode_i(mode_i),
    .src_i(src_i), .dst_i(dst_i), .len_i(len_i), .pattern_i(pattern_i),
    .busy_o(busy_o), .done_o(done_o), .req_o(req_o), .gnt_i(gnt_i),
    .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o), .rdata_i(rdata_i)
  );

  always #5 clk = ~clk;

  // Data memory: combinational read, negedge write of granted write beats.
  assign rdata_i = mem[addr_o];
  always @(negedge clk) begin
    if (req_o && gnt_i && we_o) mem[addr_o] = wdata_o;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_mem(input string tag);
    int bad = 0;
    for (int i = 0; i < WORDS; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk({tag, " mem_mismatches"}, bad, 0);
  endtask

  task automatic run_op(input string name, input dma_mode_t mode, input int src, input int dst,
                        input int len, input logic [15:0] pat, input int stall_lo, input int stall_hi,
                        input bit rnd, input bit pulse_mid, input int rst_beat);
    int B, beats, cycle, nmod, k, exp_addr;
    bit finished, exp_we;
    logic [15:0] v;
    logic [15:0] wexp[$];
    nmod = len;
    if (rst_beat >= 0) nmod = (mode == DMA_COPY) ? rst_beat / 2 : rst_beat;
    for (int j = 0; j < len; j++) begin
      v = (mode == DMA_COPY) ? ref_mem[(src + j) % WORDS] : pat;
      if (j < nmod) ref_mem[(dst + j) % WORDS] = v;
      wexp.push_back(v);
    end
    B = (len == 0) ? 0 : ((mode == DMA_FILL) ? len : 2 * len);

    mode_i = mode; src_i = src[DMEM_DEPTH-1:0]; dst_i = dst[DMEM_DEPTH-1:0];
    len_i = len[DMA_LEN_W-1:0]; pattern_i = pat; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; cycle = 1; beats = 0; finished = 0;
    while (!finished && cycle <= 400) begin
      if (pulse_mid && cycle == 2) begin
        start_i = 1'b1; mode_i = DMA_FILL; len_i = 1; pattern_i = 16'hdead; dst_i = '0;
      end else start_i = 1'b0;
      gnt_i = rnd ? ($urandom_range(0, 3) != 0) : !(cycle >= stall_lo && cycle <= stall_hi);
      if (beats < B) begin
        if (mode == DMA_FILL) begin
          k = beats; exp_addr = (dst + k) % WORDS; exp_we = 1;
        end else begin
          k = beats / 2; exp_we = beats[0];
          exp_addr = exp_we ? (dst + k) % WORDS : (src + k) % WORDS;
        end
        chk({name, " req"}, req_o, 1);
        chk({name, " busy"}, busy_o, 1);
        chk({name, " done_early"}, done_o, 0);
        chk({name, " addr"}, addr_o, exp_addr);
        chk({name, " we"}, we_o, exp_we);
        if (exp_we) chk({name, " wdata"}, wdata_o, wexp[k]);
        if (gnt_i) beats++;
        if (rst_beat >= 0 && gnt_i && beats == rst_beat) begin
          rst = 1'b1;
          @(posedge clk); #1;
          rst = 1'b0;
          chk({name, " rst busy"}, busy_o, 0);
          chk({name, " rst done"}, done_o, 0);
          chk({name, " rst req"}, req_o, 0);
          chk({name, " rst we"}, we_o, 0);
          chk({name, " rst addr"}, addr_o, 0);
          chk({name, " rst wdata"}, wdata_o, 0);
          for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk({name, " post_rst done"}, done_o, 0);
            chk({name, " post_rst req"}, req_o, 0);
          end
          finished = 1;
        end
      end else begin
        chk({name, " done"}, done_o, 1);
        chk({name, " done_busy"}, busy_o, 0);
        chk({name, " done_req"}, req_o, 0);
        @(posedge clk); #1;
        chk({name, " done_pulse"}, done_o, 0);
        finished = 1;
      end
      if (!finished) begin
        @(posedge clk); #1;
        cycle++;
      end
    end
    if (!finished) chk({name, " timeout"}, 0, 1);
    gnt_i = 1'b1;
    chk_mem(name);
  endtask

  task automatic chk_done_cycle(input string tag, input int got, input int exp);
    chk(tag, got, exp);
  endtask

  // Directed timing probe: returns the cycle after accept in which done_o is seen.
  task automatic measure(input dma_mode_t mode, input int src, input int dst, input int len,
                         input logic [15:0] pat, input int slo, input int shi, output int dcyc);
    int cyc;
    for (int j = 0; j < len; j++)
      ref_mem[(dst + j) % WORDS] = (mode == DMA_COPY) ? ref_mem[(src + j) % WORDS] : pat;
    mode_i = mode; src_i = src[DMEM_DEPTH-1:0]; dst_i = dst[DMEM_DEPTH-1:0];
    len_i = len[DMA_LEN_W-1:0]; pattern_i = pat; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; dcyc = -1;
    for (cyc = 1; cyc <= 200 && dcyc < 0; cyc++) begin
      gnt_i = !(cyc >= slo && cyc <= shi);
      if (done_o) dcyc = cyc;
      else begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    gnt_i = 1'b1;
  endtask

  initial begin
    int dc;
    rst = 1'b1; start_i = 1'b0; mode_i = DMA_COPY; src_i = '0; dst_i = '0;
    len_i = '0; pattern_i = '0; gnt_i = 1'b1;
    for (int i = 0; i < WORDS; i++) begin
      mem[i] = 16'($urandom);
      ref_mem[i] = mem[i];
    end
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", busy_o, 0);
    chk("reset done", done_o, 0);
    chk("reset req", req_o, 0);
    chk("reset we", we_o, 0);
    chk("reset addr", addr_o, 0);
    chk("reset wdata", wdata_o, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic copy: timing probe then content checks.
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333;
    ref_mem[0] = 16'h1111; ref_mem[1] = 16'h2222; ref_mem[2] = 16'h3333;
    measure(DMA_COPY, 0, 8, 3, 16'h0, 0, 0, dc);
    chk_done_cycle("copy3 done_cycle", dc, 7);
    chk("copy3 mem8", mem[8], 16'h1111);
    chk("copy3 mem10", mem[10], 16'h3333);
    chk_mem("copy3");

    measure(DMA_FILL, 0, 4, 4, 16'hBEEF, 2, 3, dc);
    chk_done_cycle("fill_stall done_cycle", dc, 7);
    chk("fill_stall mem7", mem[7], 16'hBEEF);
    chk_mem("fill_stall");

    run_op("copy3_trace", DMA_COPY, 0, 8, 3, 16'h0, 0, 0, 0, 0, -1);
    run_op("fill_stall_trace", DMA_FILL, 0, 4, 4, 16'hBEEF, 2, 3, 0, 0, -1);
    run_op("wrap", DMA_COPY, WORDS - 1, WORDS - 2, 3, 16'h0, 0, 0, 0, 0, -1);
    run_op("len0", DMA_COPY, 5, 9, 0, 16'h0, 0, 0, 0, 0, -1);
    run_op("fill_full", DMA_FILL, 17, 0, WORDS, 16'h5A5A, 0, 0, 0, 0, -1);
    chk("fill_full mem63", mem[WORDS-1], 16'h5A5A);
    for (int i = 0; i < WORDS; i++) begin
      mem[i] = 16'($urandom);
      ref_mem[i] = mem[i];
    end
    run_op("ignored_start", DMA_COPY, 10, 30, 4, 16'h0, 0, 0, 0, 1, -1);
    run_op("reset_mid", DMA_COPY, 40, 20, 5, 16'h0, 0, 0, 0, 0, 2);

    mem[0] = 16'h000A; mem[1] = 16'h000B; ref_mem[0] = 16'h000A; ref_mem[1] = 16'h000B;
    run_op("overlap", DMA_COPY, 0, 1, 2, 16'h0, 0, 0, 0, 0, -1);
    chk("overlap mem1", mem[1], 16'h000A);
    chk("overlap mem2", mem[2], 16'h000A);

    for (int r = 0; r < 8; r++) begin
      run_op("random", ($urandom_range(0, 1) != 0) ? DMA_FILL : DMA_COPY,
             $urandom_range(0, WORDS - 1), $urandom_range(0, WORDS - 1),
             $urandom_range(1, 10), 16'($urandom), 0, 0, 1, 0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_copy_engine.md
# dmem_copy_engine

Memory-side initiator that performs block copy and block fill operations on the data memory without CPU involvement. It sits between a control source (CPU MMIO register block or test bench) and a second port into the data-memory arbiter. It issues one word access per granted cycle and reports completion with a one-cycle pulse. The data memory reads and writes on the negative clock edge, so read data for an address driven in cycle N is valid before the posedge that ends cycle N.

## Interface
- `DMEM_DEPTH`, from `MiniLab_defs`: address width in words.
- `clk` in 1: single system clock; all engine state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `start_i` in 1: command strobe; sampled only in IDLE.
- `mode_i` in 1: 0 = COPY, 1 = FILL (type `dma_mode_t`).
- `src_i` in DMEM_DEPTH: COPY source start address.
- `dst_i` in DMEM_DEPTH: destination start address.
- `len_i` in DMEM_DEPTH+1: word count; 0 through 2^DMEM_DEPTH.
- `pattern_i` in 16: FILL data word.
- `busy_o` out 1: high from the cycle after an accepted start through the last access.
- `done_o` out 1: one-cycle completion pulse.
- `req_o` out 1: access request to the arbiter.
- `gnt_i` in 1: arbiter grant; a beat completes at a posedge where `req_o & gnt_i`.
- `we_o` out 1: write enable toward dmem.
- `addr_o` out DMEM_DEPTH: dmem address.
- `wdata_o` out 16: dmem write data.
- `rdata_i` in 16: dmem read data.

## Operation
- **States.** IDLE, READ, WRITE, DONE.
- **IDLE.**
  - `start_i` high: latch `mode_i`, `src_i`, `dst_i`, `len_i`, `pattern_i` into working registers.
  - `len_i == 0`: go to DONE.
  - Otherwise: COPY goes to READ; FILL goes to WRITE.
- **READ.**
  - Drives `req_o=1`, `we_o=0`, `addr_o=src_r`.
  - On grant: capture `rdata_i` into `data_r`, increment `src_r`, go to WRITE.
- **WRITE.**
  - Drives `req_o=1`, `we_o=1`, `addr_o=dst_r`.
  - `wdata_o` is `data_r` for COPY and `pattern_r` for FILL.
  - On grant: increment `dst_r` and decrement `cnt_r`.
  - If `cnt_r` was 1, go to DONE. Otherwise COPY goes to READ and FILL stays in WRITE.
- **DONE.** `done_o=1` for exactly one cycle, then IDLE.
- **No grant.** If `gnt_i` is low, hold state. `addr_o`, `we_o` and `wdata_o` stay stable, and no counters change.
- **Addresses.** Both wrap modulo 2^DMEM_DEPTH (plain width-truncated increment).
- **Overlap.** Copies always run ascending, one word at a time: word k is read before word k is written. For overlapping regions with dst > src this replicates the source prefix; this is the defined behaviour.
- **Restart.** `start_i` outside IDLE is ignored, and no queueing is done.
- **Reset.** Takes effect at any point, including mid-operation. The state returns to IDLE and every output is driven to 0: `busy_o`, `done_o`, `req_o`, `we_o`, `addr_o`, `wdata_o`. The working registers clear. A partially completed copy is not resumed.
- **Idle outputs.** Outside READ and WRITE, `req_o`, `we_o` and `addr_o` are 0, and `wdata_o` is 0.

## Timing
- Start is accepted at posedge T0. The engine enters READ or WRITE in cycle 1; `busy_o` is registered and high from cycle 1.
- With `gnt_i` held high:
  - COPY of N words occupies cycles 1..2N and `done_o` is high in cycle 2N+1.
  - FILL occupies cycles 1..N and `done_o` is high in cycle N+1.
  - `len=0` gives `done_o` in cycle 1 and `busy_o` never rises.
- **Read sampling.** `rdata_i` is sampled at the posedge closing the granted READ cycle. This requires dmem's negedge read: the address must be stable from the posedge, so `addr_o` is driven from registered state only and is never combinational from `gnt_i`.
- **Accepting the next command.** `busy_o` is low in the DONE cycle. A new `start_i` is accepted in the IDLE cycle after DONE, at the earliest.
- Each stalled cycle adds exactly one cycle to total latency.

## Structure
- **Package additions to `MiniLab_defs`:**
  - `typedef enum logic {DMA_COPY, DMA_FILL} dma_mode_t`.
  - `DMA_LEN_W = DMEM_DEPTH+1`.
- **Local to the module:** the state enum (2 bits).
- **Sub-modules:** none needed. The single FSM plus three counters/registers (`src_r`, `dst_r`, `cnt_r`) is one flat module.
- **Arbitration:** priority between this engine and the CPU is the arbiter's job, outside this block.

## Test plan
- **Basic COPY.** Preload mem[0..2] = 0x1111, 0x2222, 0x3333. COPY src=0, dst=8, len=3, `gnt_i` tied 1. Expect mem[8..10] to match, `done_o` exactly in cycle 7 after accept, and `busy_o` high in cycles 1-6.
- **FILL with grant stalls.** FILL dst=4, len=4, pattern=0xBEEF, with `gnt_i` low in cycles 2-3. Expect mem[4..7] = 0xBEEF, `addr_o` and `we_o` held during the stall, and `done_o` in cycle 7.
- **Wrap-around.** COPY src=2^DMEM_DEPTH−1, dst=2^DMEM_DEPTH−2, len=3. Expect the address sequences to wrap to 0 and 1 and the correct words to land at the top-2, top-1 and 0 addresses.
- **Length boundaries.** `len=0` gives `done_o` in cycle 1, no `req_o` and no writes. Full-memory FILL (`len=2^DMEM_DEPTH`) writes every word and then completes.
- **Ignored start and reset.** Pulse `start_i` mid-COPY and expect it to be ignored. Assert `rst` mid-COPY after 1 word: expect all outputs 0 the next cycle, state IDLE, only the first destination word written, and no `done_o`.
- **Overlapping copy.** With mem[0]=0xA, mem[1]=0xB, COPY src=0, dst=1, len=2. Expect mem[1]=0xA and mem[2]=0xA.
